// File: rtl/ccl_col_read_seq_if.sv
// Bank-read and PE-column handshake bundle for ccl_col_read_seq.
// master = sequencer side, slave = bank/PE side.
interface ccl_col_read_seq_if #(
  parameter int N_PE_COL       = 5,
  parameter int DEPTH_CCL_BANK = 4096
);
  localparam int AW = $clog2(DEPTH_CCL_BANK);

  logic [N_PE_COL-1:0][AW-1:0] raddr_col_clause_idx_bank;
  logic [N_PE_COL-1:0]         ren_col_clause_idx_bank;
  logic [N_PE_COL-1:0][4:0]    col_clause_idx_data;
  logic [N_PE_COL-1:0][4:0]    clause_idx_out;
  logic [N_PE_COL-1:0]         clause_idx_valid;
  logic [N_PE_COL-1:0]         pe_ready;

  modport master (
    output raddr_col_clause_idx_bank, ren_col_clause_idx_bank,
    output clause_idx_out, clause_idx_valid,
    input  col_clause_idx_data, pe_ready
  );

  modport slave (
    input  raddr_col_clause_idx_bank, ren_col_clause_idx_bank,
    input  clause_idx_out, clause_idx_valid,
    output col_clause_idx_data, pe_ready
  );
endinterface

// File: rtl/ccl_col_read_seq.sv
// Per-column CCL bank read sequencer with 2-entry skid FIFO per column.
// Optional stall counter enabled by defining CCL_RD_PERF_CNT_EN.
module ccl_col_read_lane #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_acc,
  input  logic          clr,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_entries,
  input  logic [4:0]    rdata,
  input  logic          pe_ready,
  output logic [AW-1:0] raddr,
  output logic          ren,
  output logic [4:0]    dout,
  output logic          valid,
  output logic          done,
  output logic          idle
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [AW-1:0] ONE_A = 1;
  localparam logic [AW:0]   ONE_R = 1;

  state_e        state, state_nxt;
  logic [AW-1:0] addr, raddr_q;
  logic [AW:0]   remain;
  logic          inflight;
  logic [4:0]    mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          pop;
  logic [2:0]    occ;

  assign valid = (fifo_cnt != 2'd0);
  assign pop   = valid & pe_ready;
  // Occupancy after this edge; issuing only below 2 keeps FIFO + inflight <= 2.
  assign occ   = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign dout  = valid ? mem[rd_ptr] : 5'd0;
  assign raddr = ren ? addr : raddr_q;
  assign done  = (state == DONE);
  assign idle  = (state == IDLE);

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    case (state)
      IDLE:  if (start_acc) state_nxt = (num_entries == '0) ? DRAIN : RUN;
      RUN: begin
        ren = (occ < 3'd2);
        if (ren && remain == ONE_R) state_nxt = DRAIN;
      end
      DRAIN: if (!inflight && !valid) state_nxt = DONE;
      DONE:  if (clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      raddr_q  <= '0;
      remain   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= ren;
      if (state == IDLE && start_acc) begin
        addr   <= base_addr;
        remain <= num_entries;
      end else if (ren) begin
        addr    <= addr + ONE_A;
        remain  <= remain - ONE_R;
        raddr_q <= addr;
      end
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk)
    if (inflight) mem[wr_ptr] <= rdata;
endmodule

module ccl_col_read_seq #(
  parameter int  N_PE_COL       = 5,
  parameter int  DEPTH_CCL_BANK = 4096,
  localparam int AW             = $clog2(DEPTH_CCL_BANK)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N_PE_COL-1:0][AW-1:0] base_addr,
  input  logic [N_PE_COL-1:0][AW:0]   num_entries,
  ccl_col_read_seq_if.master          bus,
  output logic [N_PE_COL-1:0]         col_done,
  output logic                        busy,
  output logic                        all_done,
  output logic [15:0]                 stall_cnt
);
  logic [N_PE_COL-1:0]         lane_idle;
  logic [N_PE_COL-1:0][AW-1:0] lane_raddr;
  logic [N_PE_COL-1:0]         lane_ren;
  logic [N_PE_COL-1:0][4:0]    lane_dout;
  logic [N_PE_COL-1:0]         lane_valid;
  logic                        start_acc;

  assign busy      = ~&lane_idle;
  // Lanes parked in DONE all leave together on the cycle after this pulse.
  assign all_done  = &col_done;
  assign start_acc = start & ~busy;

  assign bus.raddr_col_clause_idx_bank = lane_raddr;
  assign bus.ren_col_clause_idx_bank   = lane_ren;
  assign bus.clause_idx_out            = lane_dout;
  assign bus.clause_idx_valid          = lane_valid;

  for (genvar i = 0; i < N_PE_COL; i++) begin : g_lane
    ccl_col_read_lane #(.AW(AW)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_acc   (start_acc),
      .clr         (all_done),
      .base_addr   (base_addr[i]),
      .num_entries (num_entries[i]),
      .rdata       (bus.col_clause_idx_data[i]),
      .pe_ready    (bus.pe_ready[i]),
      .raddr       (lane_raddr[i]),
      .ren         (lane_ren[i]),
      .dout        (lane_dout[i]),
      .valid       (lane_valid[i]),
      .done        (col_done[i]),
      .idle        (lane_idle[i])
    );
  end

`ifdef CCL_RD_PERF_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= 16'd0;
    else if (start_acc)
      stall_q <= 16'd0;
    else if (|(lane_valid & ~bus.pe_ready) && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_ccl_col_read_seq.sv
// Directed bench for ccl_col_read_seq: bank model returns addr[4:0]^col one
// cycle after ren; a monitor logs accepted outputs and issue-window violations.
module tb_ccl_col_read_seq;
  localparam int N     = 5;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
`ifdef CCL_RD_PERF_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd10;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [N-1:0][AW-1:0] base_addr;
  logic [N-1:0][AW:0]   num_entries;
  logic [N-1:0]         col_done;
  logic                 busy, all_done;
  logic [15:0]          stall_cnt;

  int checks = 0, failures = 0;

  ccl_col_read_seq_if #(.N_PE_COL(N), .DEPTH_CCL_BANK(DEPTH)) bus ();

  ccl_col_read_seq #(.N_PE_COL(N), .DEPTH_CCL_BANK(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_entries (num_entries),
    .bus         (bus),
    .col_done    (col_done),
    .busy        (busy),
    .all_done    (all_done),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] bank_val(input int a, input int c);
    logic [31:0] t;
    t = a ^ c;
    return t[4:0];
  endfunction

  // Bank: data for the address read in cycle k appears in cycle k+1.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      bus.col_clause_idx_data[i] <= bus.ren_col_clause_idx_bank[i] ?
        bank_val(int'(bus.raddr_col_clause_idx_bank[i]), i) : 5'h1F;

  logic [4:0] got [N][$];
  int         raddr_log [$];
  int         ren_cnt [N];
  int         m_cnt [N];
  logic       m_inf [N];
  int         occ_viol = 0;
  int         ad_cnt = 0;

  always @(negedge clk) begin
    logic mpop;
    int   mocc;
    #1;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_inf[i] = 1'b0;
      end
    end else begin
      if (all_done) ad_cnt++;
      for (int i = 0; i < N; i++) begin
        mpop = bus.clause_idx_valid[i] & bus.pe_ready[i];
        if (mpop) got[i].push_back(bus.clause_idx_out[i]);
        if (bus.ren_col_clause_idx_bank[i]) begin
          ren_cnt[i]++;
          if (i == 0) raddr_log.push_back(int'(bus.raddr_col_clause_idx_bank[0]));
        end
        mocc = m_cnt[i] + int'(m_inf[i]) - int'(mpop);
        if (bus.ren_col_clause_idx_bank[i] && mocc >= 2) occ_viol++;
        m_cnt[i] = mocc;
        m_inf[i] = bus.ren_col_clause_idx_bank[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      got[i].delete();
      ren_cnt[i] = 0;
    end
    raddr_log.delete();
    ad_cnt = 0;
    occ_viol = 0;
  endtask

  task automatic set_all(input int b, input int n);
    for (int i = 0; i < N; i++) begin
      base_addr[i]   = AW'(b);
      num_entries[i] = (AW+1)'(n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit toggle2);
    int n;
    logic [3:0] pat;
    n = 0;
    pat = 4'b1001;
    while (all_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      if (toggle2) bus.pe_ready[2] = pat[n % 4];
      n++;
    end
    chk(tag, 64'(all_done), 64'd1);
  endtask

  task automatic check_col(input string tag, input int col, input int base, input int n);
    string t;
    t = $sformatf("%s_c%0d", tag, col);
    chk({t, "_len"}, 64'(got[col].size()), 64'(n));
    for (int k = 0; k < n && k < got[col].size(); k++)
      chk(t, 64'(got[col][k]), 64'(bank_val((base + k) % DEPTH, col)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pe_ready = '1;
    set_all(0, 0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ren",      64'(bus.ren_col_clause_idx_bank), 64'd0);
    chk("rst_valid",    64'(bus.clause_idx_valid), 64'd0);
    chk("rst_out",      64'(bus.clause_idx_out), 64'd0);
    chk("rst_raddr",    64'(bus.raddr_col_clause_idx_bank), 64'd0);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_col_done", 64'(col_done), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);
    chk("rst_stall",    64'(stall_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run: 8 entries from address 0, outputs on cycles 3..10
    set_all(0, 8);
    clear_logs();
    pulse_start();
    chk("basic_ren_c1",   64'(bus.ren_col_clause_idx_bank), 64'h1F);
    chk("basic_raddr_c1", 64'(bus.raddr_col_clause_idx_bank[0]), 64'd0);
    chk("basic_busy",     64'(busy), 64'd1);
    @(negedge clk);
    chk("basic_valid_c2", 64'(bus.clause_idx_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("basic_valid_k%0d", k), 64'(bus.clause_idx_valid), 64'h1F);
      chk($sformatf("basic_out0_k%0d", k), 64'(bus.clause_idx_out[0]), 64'(bank_val(k, 0)));
      chk($sformatf("basic_out4_k%0d", k), 64'(bus.clause_idx_out[4]), 64'(bank_val(k, 4)));
    end
    wait_done("basic_all_done", 1'b0);
    @(negedge clk);
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_done_clr",   64'(col_done), 64'd0);
    chk("basic_ad_pulses",  64'(ad_cnt), 64'd1);
    for (int i = 0; i < N; i++) check_col("basic", i, 0, 8);

    // Address wrap 4094 -> 1
    set_all(4094, 4);
    clear_logs();
    pulse_start();
    wait_done("wrap_all_done", 1'b0);
    @(negedge clk);
    chk("wrap_nraddr", 64'(raddr_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < raddr_log.size(); k++)
      chk($sformatf("wrap_raddr%0d", k), 64'(raddr_log[k]), 64'((4094 + k) % DEPTH));
    chk("wrap_raddr_hold", 64'(bus.raddr_col_clause_idx_bank[0]), 64'd1);
    for (int i = 0; i < N; i++) check_col("wrap", i, 4094, 4);

    // Backpressure on column 2 only
    set_all(100, 16);
    clear_logs();
    pulse_start();
    wait_done("bp_all_done", 1'b1);
    bus.pe_ready = '1;
    @(negedge clk);
    for (int i = 0; i < N; i++) check_col("bp", i, 100, 16);
    chk("bp_occ_viol", 64'(occ_viol), 64'd0);
    chk("bp_ad_pulses", 64'(ad_cnt), 64'd1);

    // Zero-length column 1
    set_all(0, 3);
    num_entries[1] = '0;
    clear_logs();
    pulse_start();
    chk("zero_done_c1", 64'(col_done), 64'd0);
    @(negedge clk);
    chk("zero_done_c2", 64'(col_done), 64'h02);
    wait_done("zero_all_done", 1'b0);
    @(negedge clk);
    chk("zero_ren1", 64'(ren_cnt[1]), 64'd0);
    check_col("zero", 1, 0, 0);
    check_col("zero", 0, 0, 3);
    check_col("zero", 4, 0, 3);

    // Start while busy is ignored
    set_all(10, 6);
    clear_logs();
    pulse_start();
    @(negedge clk);
    set_all(0, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_all_done", 1'b0);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_col("ign", i, 10, 6);
    chk("ign_ad_pulses", 64'(ad_cnt), 64'd1);

    // Asynchronous reset mid-run
    set_all(200, 20);
    clear_logs();
    pulse_start();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_ren",   64'(bus.ren_col_clause_idx_bank), 64'd0);
    chk("mrst_valid", 64'(bus.clause_idx_valid), 64'd0);
    chk("mrst_out",   64'(bus.clause_idx_out), 64'd0);
    chk("mrst_raddr", 64'(bus.raddr_col_clause_idx_bank), 64'd0);
    chk("mrst_busy",  64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh start after reset
    set_all(300, 5);
    clear_logs();
    pulse_start();
    wait_done("fresh_all_done", 1'b0);
    @(negedge clk);
    chk("fresh_nraddr", 64'(raddr_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < raddr_log.size(); k++)
      chk($sformatf("fresh_raddr%0d", k), 64'(raddr_log[k]), 64'(300 + k));
    for (int i = 0; i < N; i++) check_col("fresh", i, 300, 5);

    // Full stall: valid held with ready low for 10 counted cycles
    bus.pe_ready = '0;
    set_all(0, 4);
    clear_logs();
    pulse_start();
    repeat (12) @(negedge clk);
    chk("stall_cnt",   64'(stall_cnt), 64'(STALL_EXP));
    chk("stall_valid", 64'(bus.clause_idx_valid), 64'h1F);
    chk("stall_noren", 64'(bus.ren_col_clause_idx_bank), 64'd0);
    bus.pe_ready = '1;
    wait_done("stall_all_done", 1'b0);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_col("stall", i, 0, 4);
    chk("stall_occ_viol", 64'(occ_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
